// File: rtl/snn_pkg.sv
// Shared spike-network packet layout and occupancy FSM states.
package snn_pkg;
  localparam int DX_W     = 9;
  localparam int DY_W     = 9;
  localparam int AXON_W   = 8;
  localparam int TICK_W   = 4;
  localparam int PACKET_W = DX_W + DY_W + AXON_W + TICK_W;

  typedef struct packed {
    logic [DX_W-1:0]   dx;
    logic [DY_W-1:0]   dy;
    logic [AXON_W-1:0] axon;
    logic [TICK_W-1:0] tick_offset;
  } packet_t;

  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_NONEMPTY = 1'b1
  } occ_state_e;
endpackage

// File: rtl/spike_packet_buffer_if.sv
// Neuron-grid ingress and router egress bundle of the spike buffer.
interface spike_packet_buffer_if
  import snn_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PACKET_W-1:0] packet_in;
  logic                spike_out_valid;
  logic                local_buffers_full;
  logic [PACKET_W-1:0] packet_out;
  logic                packet_out_valid;
  logic                packet_out_ready;
  logic                empty;
  logic [CW-1:0]       count;
  logic                overflow;

  modport master (
    output packet_in, spike_out_valid, packet_out_ready,
    input  local_buffers_full, packet_out, packet_out_valid,
    input  empty, count, overflow
  );

  modport slave (
    input  packet_in, spike_out_valid, packet_out_ready,
    output local_buffers_full, packet_out, packet_out_valid,
    output empty, count, overflow
  );
endinterface

// File: rtl/spike_fifo_mem.sv
// Packet storage: one synchronous write port, one asynchronous read port.
module spike_fifo_mem
  import snn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  packet_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output packet_t       o_rdata
);
  packet_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/spike_packet_buffer.sv
// FWFT spike packet FIFO between neuron grid and router.
// Optional saturating stats counters: SPIKE_PACKET_BUFFER_STATS_EN.
module spike_packet_buffer
  import snn_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spike_packet_buffer_if.slave bus
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  ,
  output logic [15:0]          accepted_count,
  output logic [15:0]          dropped_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_full;
  logic          r_ovf;
  occ_state_e    r_state;
  occ_state_e    w_state_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  packet_t       w_rd_data;

  assign w_pop  = (r_state == ST_NONEMPTY) && bus.packet_out_ready;
  // A full FIFO still accepts when the head leaves this same cycle.
  assign w_push = bus.spike_out_valid &&
                  ((r_count < CW'(DEPTH)) || w_pop);
  assign w_drop = bus.spike_out_valid && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      w_push && !w_pop: w_count_nxt = r_count + CW'(1);
      w_pop && !w_push: w_count_nxt = r_count - CW'(1);
      default:          w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:
        if (w_push) w_state_nxt = ST_NONEMPTY;
      ST_NONEMPTY:
        if (r_count == CW'(1) && w_pop && !w_push)
          w_state_nxt = ST_EMPTY;
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_state  <= ST_EMPTY;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt >= CW'(DEPTH - FULL_MARGIN));
      if (w_drop) r_ovf <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  spike_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (packet_t'(bus.packet_in)),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign bus.packet_out_valid   = (r_state == ST_NONEMPTY);
  assign bus.packet_out         = bus.packet_out_valid ?
                                  PACKET_W'(w_rd_data) : '0;
  assign bus.empty              = (r_count == '0);
  assign bus.count              = r_count;
  assign bus.overflow           = r_ovf;
  assign bus.local_buffers_full = r_full;

`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && r_acc_cnt != 16'hFFFF)
        r_acc_cnt <= r_acc_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign accepted_count = r_acc_cnt;
  assign dropped_count  = r_drop_cnt;
`endif
endmodule

// File: tb/tb_spike_packet_buffer.sv
// Directed self-checking bench for spike_packet_buffer.
// Build with SPIKE_PACKET_BUFFER_STATS_EN to also cover the stats counters.
module tb_spike_packet_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spike_packet_buffer_if #(.DEPTH(16)) bus ();

`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  logic [15:0] acc_cnt;
  logic [15:0] drop_cnt;
`endif

  spike_packet_buffer #(
    .DEPTH       (16),
    .FULL_MARGIN (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
    ,
    .accepted_count (acc_cnt),
    .dropped_count  (drop_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.packet_in       = 30'(base + i);
      bus.spike_out_valid = 1'b1;
      tick();
    end
    bus.spike_out_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.spike_out_valid  = 1'b0;
    bus.packet_out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [29:0] q[$];
  int pushed;
  int popped;
  logic in_v;
  logic rdy;
  logic pop_m;

  initial begin
    bus.packet_in        = '0;
    bus.spike_out_valid  = 1'b0;
    bus.packet_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.packet_out_valid), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.local_buffers_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_pkt", 32'(bus.packet_out), 0);
    reset = 1'b0;
    #1;

    // single packet, FWFT latency of one cycle
    bus.packet_in        = 30'h0000_0ABC;
    bus.spike_out_valid  = 1'b1;
    bus.packet_out_ready = 1'b1;
    tick();
    bus.spike_out_valid = 1'b0;
    #1;
    chk("fwft_valid", 32'(bus.packet_out_valid), 1);
    chk("fwft_pkt", 32'(bus.packet_out), 32'h0ABC);
    tick();
    chk("fwft_empty", 32'(bus.empty), 1);
    chk("fwft_count", 32'(bus.count), 0);

    // fill past the full margin and overflow
    bus.packet_out_ready = 1'b0;
    push_n(1, 13);
    chk("full_13", 32'(bus.local_buffers_full), 0);
    push_n(14, 1);
    chk("full_14", 32'(bus.local_buffers_full), 1);
    chk("count_14", 32'(bus.count), 14);
    push_n(15, 2);
    chk("count_16", 32'(bus.count), 16);
    chk("ovf_16", 32'(bus.overflow), 0);
    push_n(17, 1);
    chk("count_drop", 32'(bus.count), 16);
    chk("ovf_set", 32'(bus.overflow), 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.packet_out_valid), 1);
      chk("hold_pkt", 32'(bus.packet_out), 1);
      tick();
    end
    bus.packet_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("drain_pkt", 32'(bus.packet_out), 32'(i));
      tick();
    end
    bus.packet_out_ready = 1'b0;
    #1;
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_valid", 32'(bus.packet_out_valid), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
    chk("stat_acc", 32'(acc_cnt), 17);
    chk("stat_drop", 32'(drop_cnt), 1);
`endif

    // push and pop together while full
    do_reset();
    chk("ovf_cleared", 32'(bus.overflow), 0);
    push_n(1, 16);
    chk("sp_count", 32'(bus.count), 16);
    bus.packet_in        = 30'd99;
    bus.spike_out_valid  = 1'b1;
    bus.packet_out_ready = 1'b1;
    tick();
    bus.spike_out_valid  = 1'b0;
    bus.packet_out_ready = 1'b0;
    #1;
    chk("sp_count_kept", 32'(bus.count), 16);
    chk("sp_ovf", 32'(bus.overflow), 0);
    chk("sp_head", 32'(bus.packet_out), 2);
    bus.packet_out_ready = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      #1;
      chk("sp_drain", 32'(bus.packet_out),
          (i == 17) ? 32'd99 : 32'(i));
      tick();
    end
    bus.packet_out_ready = 1'b0;
    #1;

    // random ready traffic across pointer wrap
    q.delete();
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 600 && popped < 40; cyc++) begin
      in_v = (pushed < 40) && ($urandom_range(0, 1) == 1);
      rdy  = ($urandom_range(0, 2) != 0);
      bus.packet_in        = 30'(32'h100 + pushed);
      bus.spike_out_valid  = in_v;
      bus.packet_out_ready = rdy;
      #1;
      chk("wrap_valid", 32'(bus.packet_out_valid),
          32'(q.size() != 0));
      if (q.size() != 0)
        chk("wrap_pkt", 32'(bus.packet_out), 32'(q[0]));
      pop_m = (q.size() != 0) && rdy;
      if (pop_m) begin
        void'(q.pop_front());
        popped++;
      end
      if (in_v && (q.size() < 16 || pop_m)) begin
        q.push_back(30'(32'h100 + pushed));
        pushed++;
      end
      tick();
    end
    bus.spike_out_valid  = 1'b0;
    bus.packet_out_ready = 1'b0;
    chk("wrap_done", 32'(popped), 40);

    // reset mid-stream
    do_reset();
    push_n(1, 9);
    chk("mid_count", 32'(bus.count), 9);
    reset = 1'b1;
    tick();
    chk("mr_count", 32'(bus.count), 0);
    chk("mr_valid", 32'(bus.packet_out_valid), 0);
    chk("mr_ovf", 32'(bus.overflow), 0);
    chk("mr_pkt", 32'(bus.packet_out), 0);
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
    chk("mr_acc", 32'(acc_cnt), 0);
    chk("mr_drop", 32'(drop_cnt), 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_empty", 32'(bus.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
